// File: rtl/key_event_capture.sv
// Eight-key capture: 2-flop sync, per-key debounce, rising-edge pending set, and a
// one-hot presenter FSM for an 8:3 encoder. Define KEYCAP_OVERRUN_EN to add the sticky overrun flag.
module key_event_capture #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic K7, K6, K5, K4, K3, K2, K1, K0,
    input  logic ack,
`ifdef KEYCAP_OVERRUN_EN
    output logic overrun,
`endif
    output logic en,
    output logic Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0
);
    localparam logic [3:0] LP_DEB = 4'(DEB_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

    logic [7:0]      w_k;
    logic [7:0]      r_sync1, r_sync2, r_deb, r_deb_d, r_pend;
    logic [7:0][3:0] r_cnt;
    logic [2:0]      r_sel, w_hi;
    logic [7:0]      w_rise, w_clr, w_y;
    logic            w_load;
    state_t          r_state, w_next;

    assign w_k = {K7, K6, K5, K4, K3, K2, K1, K0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_k;
            r_sync2 <= r_sync1;
        end
    end

    // A level change is accepted one edge after the counter has reached DEB_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_deb <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_DEB) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign w_rise = r_deb & ~r_deb_d;
    assign w_clr  = (r_state == S_PRESENT && ack) ? (8'(1) << r_sel) : 8'h00;

    // Set beats clear, so a re-press landing on the ack cycle is kept as a new event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_d <= '0;
            r_pend  <= '0;
        end else begin
            r_deb_d <= r_deb;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
        end
    end

`ifdef KEYCAP_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (|(w_rise & r_pend & ~w_clr))
            overrun <= 1'b1;
    end
`endif

    always_comb begin
        w_hi = 3'd0;
        for (int i = 0; i < 8; i++)
            if (r_pend[i]) w_hi = 3'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) r_sel <= w_hi;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        en     = 1'b0;
        w_y    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_load = 1'b1;
                    w_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                en  = 1'b1;
                w_y = 8'(1) << r_sel;
                if (ack) w_next = S_GAP;
            end
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = w_y;
endmodule

// File: tb/tb_key_event_capture.sv
// Bench for key_event_capture: vector table of press patterns plus hand sequences for
// gap timing, bounce rejection, re-press merge and mid-presentation reset.
module tb_key_event_capture;
    localparam int DEB = 4;
    localparam int LAT = DEB + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] kin = 8'h00;
    logic       en;
    logic [7:0] yv;
`ifdef KEYCAP_OVERRUN_EN
    logic       overrun;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         ack_mode = 0;   // 0 low, 1 ack whenever en, 2 held high, 3 driven by hand
    logic [7:0] sbq[$];

    typedef struct {
        logic [7:0] keys;
        int         mode;
        int         lat;
        logic [7:0] first;
    } vec_t;
    vec_t tbl[5];

    key_event_capture #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst),
        .K7(kin[7]), .K6(kin[6]), .K5(kin[5]), .K4(kin[4]),
        .K3(kin[3]), .K2(kin[2]), .K1(kin[1]), .K0(kin[0]),
        .ack(ack),
`ifdef KEYCAP_OVERRUN_EN
        .overrun(overrun),
`endif
        .en(en),
        .Y7(yv[7]), .Y6(yv[6]), .Y5(yv[5]), .Y4(yv[4]),
        .Y3(yv[3]), .Y2(yv[2]), .Y1(yv[1]), .Y0(yv[0])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ack_mode == 1) ack = en;
        else if (ack_mode == 2) ack = 1'b1;
        else if (ack_mode == 0) ack = 1'b0;
    end

    // Scoreboard: each accepted presentation must match the oldest expected code.
    always @(negedge clk) begin
        if (!rst) begin
            chk("y_legal", {31'd0, $onehot0(yv) && (en || yv == 8'h00)}, 32'd1);
            if (en && ack) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_extra: got %0h expected none", yv);
                end else begin
                    chk("sb_code", {24'd0, yv}, {24'd0, sbq.pop_front()});
                end
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        ack_mode = 0;
        ack      = 1'b0;
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_en(output int lat);
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (en) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_quiet(input string name, input int n);
        logic seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (en) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    task automatic push_keys(input logic [7:0] keys);
        logic [7:0] one = 8'h01;
        for (int i = 7; i >= 0; i--)
            if (keys[i]) sbq.push_back(one << i);
    endtask

    initial begin
        int lat;
        int en_cyc;

        tbl[0] = '{keys: 8'h08, mode: 0, lat: LAT, first: 8'h08};
        tbl[1] = '{keys: 8'h42, mode: 1, lat: LAT, first: 8'h40};
        tbl[2] = '{keys: 8'h01, mode: 2, lat: LAT, first: 8'h01};
        tbl[3] = '{keys: 8'hFF, mode: 1, lat: LAT, first: 8'h80};
        tbl[4] = '{keys: 8'h80, mode: 1, lat: LAT, first: 8'h80};

        #2;
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_y", {24'd0, yv}, 32'd0);
`ifdef KEYCAP_OVERRUN_EN
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
`endif

        foreach (tbl[t]) begin
            kin = 8'h00;
            do_reset();
            ack_mode = tbl[t].mode;
            if (tbl[t].mode != 0) push_keys(tbl[t].keys);
            kin = tbl[t].keys;
            wait_en(lat);
            chk("lat", lat, tbl[t].lat);
            chk("first_y", {24'd0, yv}, {24'd0, tbl[t].first});
            if (tbl[t].mode == 0) begin
                repeat (20) @(posedge clk);
                #1;
                chk("hold_en", {31'd0, en}, 32'd1);
                chk("hold_y", {24'd0, yv}, {24'd0, tbl[t].first});
            end else begin
                en_cyc = 1;
                for (int c = 0; c < 200; c++) begin
                    @(posedge clk);
                    #1;
                    if (en) en_cyc++;
                    if (sbq.size() == 0) break;
                end
                chk("drain", sbq.size(), 0);
                chk("en_cycles", en_cyc, $countones(tbl[t].keys));
                wait_quiet("no_extra", 10);
            end
        end

        // K6 then K1 with a single-cycle manual ack: GAP, IDLE, then K1
        kin = 8'h00;
        do_reset();
        ack_mode = 3;
        push_keys(8'h42);
        kin = 8'h42;
        wait_en(lat);
        chk("gap_first", {24'd0, yv}, 32'h40);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        chk("gap_en", {31'd0, en}, 32'd0);
        chk("gap_y", {24'd0, yv}, 32'd0);
        @(posedge clk);
        #1 chk("idle_en", {31'd0, en}, 32'd0);
        @(posedge clk);
        #1 chk("second_y", {24'd0, yv}, 32'h02);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        chk("gap_drain", sbq.size(), 0);

        // K5 bounce never survives the debounce window
        kin = 8'h00;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            kin = (b % 2 == 0) ? 8'h20 : 8'h00;
            @(posedge clk);
            #1;
        end
        kin = 8'h00;
        wait_quiet("bounce", 30);

        // K2 press, release, re-press before ack merges into one event
        do_reset();
        ack_mode = 3;
        kin = 8'h04;
        wait_en(lat);
        chk("rp_lat", lat, LAT);
        kin = 8'h00;
        repeat (12) @(posedge clk);
        #1 kin = 8'h04;
        repeat (12) @(posedge clk);
        #1;
        chk("rp_y", {24'd0, yv}, 32'h04);
`ifdef KEYCAP_OVERRUN_EN
        chk("rp_ovr", {31'd0, overrun}, 32'd1);
`endif
        sbq.push_back(8'h04);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        wait_quiet("rp_single", 20);
        chk("rp_drain", sbq.size(), 0);

        // Partial-cycle reset during presentation with K4 released
        kin = 8'h00;
        do_reset();
        kin = 8'h10;
        wait_en(lat);
        chk("r4_y", {24'd0, yv}, 32'h10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_en", {31'd0, en}, 32'd0);
        chk("async_y", {24'd0, yv}, 32'd0);
        kin = 8'h00;
        #1 rst = 1'b0;
        wait_quiet("r4_discard", 30);

        // Same reset with K4 still held: re-registers as a fresh press
        kin = 8'h10;
        wait_en(lat);
        chk("r4_first", {24'd0, yv}, 32'h10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_en2", {31'd0, en}, 32'd0);
        #1 rst = 1'b0;
        wait_en(lat);
        chk("held_lat", lat, LAT);
        chk("held_y", {24'd0, yv}, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
